pi_control_sat: RTL

//  Parametrised, fully pipelined PI controller; successor to the fixed 16-bit pi_control.

---
 rtl/pi_control_sat.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/pi_control_sat.sv
// Pipelined PI controller with integrator clamp, output offset and output saturation.
// 3-cycle latency (capture, integrate, sum/saturate); no backpressure, one sample per clock.
module pi_control_sat #(
    parameter int D_WIDTH   = 16,
    parameter int Q_WIDTH   = 16,
    parameter int KP_WIDTH  = 24,
    parameter int KI_WIDTH  = 32,
    parameter int KP_FRAC   = 16,
    parameter int KI_FRAC   = 26,
    parameter int ACC_WIDTH = 48
) (
    input  logic                        clk_i,
    input  logic                        rst_n_i,
    input  logic                        en_i,
    input  logic                        clr_i,
    input  logic                        d_valid_i,
    input  logic signed [D_WIDTH-1:0]   d_i,
    input  logic signed [KP_WIDTH-1:0]  kp_i,
    input  logic signed [KI_WIDTH-1:0]  ki_i,
    input  logic [ACC_WIDTH-2:0]        int_lim_i,
    input  logic signed [Q_WIDTH-1:0]   q_offset_i,
    output logic                        q_valid_o,
    output logic signed [Q_WIDTH-1:0]   q_o,
    output logic                        sat_hi_o,
    output logic                        sat_lo_o,
    output logic                        int_sat_o
);

    localparam int PW  = D_WIDTH + KP_WIDTH;
    localparam int IW  = D_WIDTH + KI_WIDTH;
    localparam int SW  = ((ACC_WIDTH > IW) ? ACC_WIDTH : IW) + 2;
    localparam int PSW = PW - KP_FRAC;
    localparam int AHW = ACC_WIDTH - KI_FRAC;
    localparam int OW  = ACC_WIDTH + 2;

    localparam logic signed [OW-1:0] Q_MAX = {{(OW-Q_WIDTH+1){1'b0}}, {(Q_WIDTH-1){1'b1}}};
    localparam logic signed [OW-1:0] Q_MIN = {{(OW-Q_WIDTH+1){1'b1}}, {(Q_WIDTH-1){1'b0}}};

    logic accept;
    assign accept = d_valid_i & en_i & ~clr_i;

    // S1: full-precision products
    logic signed [PW-1:0] d_px, kp_x, p_nxt;
    logic signed [IW-1:0] d_ix, ki_x, i_nxt;

    assign d_px  = {{KP_WIDTH{d_i[D_WIDTH-1]}}, d_i};
    assign kp_x  = {{D_WIDTH{kp_i[KP_WIDTH-1]}}, kp_i};
    assign p_nxt = d_px * kp_x;
    assign d_ix  = {{KI_WIDTH{d_i[D_WIDTH-1]}}, d_i};
    assign ki_x  = {{D_WIDTH{ki_i[KI_WIDTH-1]}}, ki_i};
    assign i_nxt = d_ix * ki_x;

    logic                       v1;
    logic signed [PW-1:0]       p1;
    logic signed [IW-1:0]       i1;
    logic [ACC_WIDTH-2:0]       lim1;
    logic signed [Q_WIDTH-1:0]  off1;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v1   <= 1'b0;
            p1   <= '0;
            i1   <= '0;
            lim1 <= '0;
            off1 <= '0;
        end else begin
            v1 <= accept;
            if (accept) begin
                p1   <= p_nxt;
                i1   <= i_nxt;
                lim1 <= int_lim_i;
                off1 <= q_offset_i;
            end
        end
    end

    // S2: integrate with a sum wide enough that it never wraps, then clamp to +/-lim
    logic signed [ACC_WIDTH-1:0] acc;
    logic signed [SW-1:0]        a_sum, lim_pos, lim_neg;
    logic signed [ACC_WIDTH-1:0] acc_nxt;
    logic                        isat_nxt;

    assign a_sum   = {{(SW-ACC_WIDTH){acc[ACC_WIDTH-1]}}, acc} + {{(SW-IW){i1[IW-1]}}, i1};
    assign lim_pos = {{(SW-ACC_WIDTH+1){1'b0}}, lim1};
    assign lim_neg = -lim_pos;

    always_comb begin
        acc_nxt  = a_sum[ACC_WIDTH-1:0];
        isat_nxt = 1'b0;
        if (a_sum > lim_pos) begin
            acc_nxt  = lim_pos[ACC_WIDTH-1:0];
            isat_nxt = 1'b1;
        end else if (a_sum < lim_neg) begin
            acc_nxt  = lim_neg[ACC_WIDTH-1:0];
            isat_nxt = 1'b1;
        end
    end

    logic                       v2;
    logic signed [PSW-1:0]      ps2;
    logic signed [Q_WIDTH-1:0]  off2;
    logic                       isat2;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            v2    <= 1'b0;
            acc   <= '0;
            ps2   <= '0;
            off2  <= '0;
            isat2 <= 1'b0;
        end else if (clr_i) begin
            v2  <= 1'b0;
            acc <= '0;
        end else begin
            v2 <= v1;
            if (v1) begin
                acc   <= acc_nxt;
                isat2 <= isat_nxt;
                ps2   <= PSW'(p1 >>> KP_FRAC);
                off2  <= off1;
            end
        end
    end

    // S3: acc already holds this sample's integral, since S3 reads it one edge after S2 wrote it
    logic signed [AHW-1:0]     acc_hi;
    logic signed [OW-1:0]      s_sum;
    logic signed [Q_WIDTH-1:0] q_nxt;
    logic                      hi_nxt, lo_nxt;

    assign acc_hi = AHW'(acc >>> KI_FRAC);
    assign s_sum  = {{(OW-PSW){ps2[PSW-1]}}, ps2}
                  + {{(OW-AHW){acc_hi[AHW-1]}}, acc_hi}
                  + {{(OW-Q_WIDTH){off2[Q_WIDTH-1]}}, off2};

    always_comb begin
        q_nxt  = s_sum[Q_WIDTH-1:0];
        hi_nxt = 1'b0;
        lo_nxt = 1'b0;
        if (s_sum > Q_MAX) begin
            q_nxt  = Q_MAX[Q_WIDTH-1:0];
            hi_nxt = 1'b1;
        end else if (s_sum < Q_MIN) begin
            q_nxt  = Q_MIN[Q_WIDTH-1:0];
            lo_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            q_valid_o <= 1'b0;
            q_o       <= '0;
            sat_hi_o  <= 1'b0;
            sat_lo_o  <= 1'b0;
            int_sat_o <= 1'b0;
        end else begin
            q_valid_o <= v2 & ~clr_i;
            if (v2 && !clr_i) begin
                q_o       <= q_nxt;
                sat_hi_o  <= hi_nxt;
                sat_lo_o  <= lo_nxt;
                int_sat_o <= isat2;
            end
        end
    end

endmodule
